// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU register-space responder: FSM encoding,
// 68030 transfer-size codes, default timing parameters and byte-lane decode.
package cpu_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_WAIT   = 3'd2,
      ST_ACK    = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

   localparam logic [1:0] SIZ_LONG  = 2'b00;
   localparam logic [1:0] SIZ_BYTE  = 2'b01;
   localparam logic [1:0] SIZ_WORD  = 2'b10;
   localparam logic [1:0] SIZ_3BYTE = 2'b11;

   localparam int DEF_WAIT_CYCLES = 2;
   localparam int DEF_DS_TIMEOUT  = 15;

   // Lanes run from BE[3] (offset 0) downward; shifting by the offset clips
   // transfers that would spill past the last lane of the long word.
   function automatic logic [3:0] calc_be(input logic [1:0] siz, input logic [1:0] off);
      logic [3:0] mask;
      case (siz)
         SIZ_BYTE:  mask = 4'b1000;
         SIZ_WORD:  mask = 4'b1100;
         SIZ_3BYTE: mask = 4'b1110;
         default:   mask = 4'b1111;
      endcase
      return mask >> off;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level into the CLK domain.
module sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/cpu_reg_responder.sv
// 68030 bus-cycle responder for a 32-bit register space: decodes byte lanes,
// issues one read/write strobe per AS assertion and answers with DSACK1:0.
module cpu_reg_responder
   import cpu_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter int DS_TIMEOUT  = DEF_DS_TIMEOUT
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       AS,
   input  logic       DS,
   input  logic       RW,
   input  logic [6:0] ADDR,
   input  logic [1:0] SIZ,
   input  logic       CS,
   output logic [4:0] REG_ADDR,
   output logic [3:0] BE,
   output logic       RD_STB,
   output logic       WR_STB,
   output logic       DATA_OE,
   output logic       DSACK0,
   output logic       DSACK1
);

   localparam int CMAX = (WAIT_CYCLES > DS_TIMEOUT) ? WAIT_CYCLES : DS_TIMEOUT;
   localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);
   localparam logic [CW-1:0] TO_LAST   = CW'(DS_TIMEOUT - 1);
   localparam logic [CW-1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

   logic          as_s;
   logic          ds_s;
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]    settle_q;
   logic          armed_q;
   logic          rw_q;
   logic [4:0]    reg_addr_q;
   logic [3:0]    be_q;
   logic          rd_stb_q;
   logic          wr_stb_q;
   logic          data_oe_q;
   logic          dsack_q;
   logic          go_idle_d;

   sync2 u_sync_as (.clk_i(CLK), .rst_i(RESET), .d_i(AS), .q_o(as_s));
   sync2 u_sync_ds (.clk_i(CLK), .rst_i(RESET), .d_i(DS), .q_o(ds_s));

   always_comb begin
      go_idle_d = 1'b0;
      case (state_q)
         ST_DECODE:       go_idle_d = !as_s || (!ds_s && (cnt_q == TO_LAST));
         ST_WAIT, ST_HOLD: go_idle_d = !as_s;
         default:         go_idle_d = 1'b0;
      endcase
   end

   // settle_q masks the synchronizer's post-reset zeros so that a CPU still
   // holding AS across a reset is not mistaken for a fresh cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         settle_q   <= 2'b00;
         armed_q    <= 1'b0;
         rw_q       <= 1'b0;
         reg_addr_q <= '0;
         be_q       <= '0;
         rd_stb_q   <= 1'b0;
         wr_stb_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         dsack_q    <= 1'b0;
      end else begin
         settle_q <= {settle_q[0], 1'b1};
         rd_stb_q <= 1'b0;
         wr_stb_q <= 1'b0;
         if (go_idle_d) begin
            state_q    <= ST_IDLE;
            reg_addr_q <= '0;
            be_q       <= '0;
            data_oe_q  <= 1'b0;
            dsack_q    <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  armed_q <= settle_q[1] & ~as_s;
                  if (as_s && CS && armed_q) begin
                     state_q    <= ST_DECODE;
                     reg_addr_q <= ADDR[6:2];
                     be_q       <= calc_be(SIZ, ADDR[1:0]);
                     rw_q       <= RW;
                     cnt_q      <= '0;
                  end
               end
               ST_DECODE: begin
                  if (ds_s) begin
                     rd_stb_q  <= rw_q;
                     data_oe_q <= rw_q;
                     if (WAIT_CYCLES == 0) begin
                        state_q  <= ST_ACK;
                        dsack_q  <= 1'b1;
                        wr_stb_q <= ~rw_q;
                     end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= WAIT_LOAD;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               ST_WAIT: begin
                  if (cnt_q == '0) begin
                     state_q  <= ST_ACK;
                     dsack_q  <= 1'b1;
                     wr_stb_q <= ~rw_q;
                  end else begin
                     cnt_q <= cnt_q - CW'(1);
                  end
               end
               ST_ACK:  state_q <= ST_HOLD;
               ST_HOLD: state_q <= ST_HOLD;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign REG_ADDR = reg_addr_q;
   assign BE       = be_q;
   assign RD_STB   = rd_stb_q;
   assign WR_STB   = wr_stb_q;
   assign DATA_OE  = data_oe_q;
   assign DSACK0   = dsack_q;
   assign DSACK1   = dsack_q;

endmodule

// File: tb/tb_cpu_reg_responder.sv
// Scoreboard bench for cpu_reg_responder: directed bus cycles push expected
// strobe/acknowledge events; a negedge monitor pops and compares them.
module tb_cpu_reg_responder;

   logic       CLK = 1'b0;
   logic       RESET, AS, DS, RW, CS;
   logic [6:0] ADDR;
   logic [1:0] SIZ;
   logic [4:0] REG_ADDR;
   logic [3:0] BE;
   logic       RD_STB, WR_STB, DATA_OE, DSACK0, DSACK1;

   always #5 CLK = ~CLK;

   cpu_reg_responder #(.WAIT_CYCLES(2), .DS_TIMEOUT(15)) dut (
      .CLK(CLK), .RESET(RESET), .AS(AS), .DS(DS), .RW(RW), .ADDR(ADDR), .SIZ(SIZ), .CS(CS),
      .REG_ADDR(REG_ADDR), .BE(BE), .RD_STB(RD_STB), .WR_STB(WR_STB), .DATA_OE(DATA_OE),
      .DSACK0(DSACK0), .DSACK1(DSACK1)
   );

   typedef enum int {EV_RD = 0, EV_WR = 1, EV_ACK = 2} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [4:0] ra;
      logic [3:0] be;
      logic       oe;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0, n_fail = 0;
   int  cyc = 0, t0 = 0;
   int  rd_cyc = -1, ack_cyc = -1;
   int  stb_cnt = 0, wr_cnt = 0, ack_cnt = 0, oe_cnt = 0, out_cnt = 0;
   logic ack_prev = 1'b0;

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   task automatic check_ev(input ev_kind_t k, input string nm);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: unexpected event ra=%0d be=%b oe=%b, required no event", nm, REG_ADDR, BE, DATA_OE);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.ra !== REG_ADDR || e.be !== BE || e.oe !== DATA_OE) begin
            n_fail++;
            $display("FAIL %s: got kind=%0d ra=%0d be=%b oe=%b, required kind=%0d ra=%0d be=%b oe=%b",
                     nm, k, REG_ADDR, BE, DATA_OE, e.kind, e.ra, e.be, e.oe);
         end
      end
   endtask

   initial forever begin
      @(negedge CLK);
      if (RESET !== 1'b1) begin
         if (RD_STB) begin
            rd_cyc = cyc;
            check_ev(EV_RD, "rd_stb");
         end
         if (WR_STB) check_ev(EV_WR, "wr_stb");
         if (DSACK0 && !ack_prev) begin
            ack_cyc = cyc;
            check_ev(EV_ACK, "dsack");
         end
         n_cmp++;
         if ((RD_STB && WR_STB) || (DSACK0 !== DSACK1)) begin
            n_fail++;
            $display("FAIL invariant: rd=%b wr=%b dsack0=%b dsack1=%b, required exclusive strobes and equal dsack",
                     RD_STB, WR_STB, DSACK0, DSACK1);
         end
      end
      ack_prev = DSACK0;
      stb_cnt += int'(RD_STB | WR_STB);
      wr_cnt  += int'(WR_STB);
      ack_cnt += int'(DSACK0 | DSACK1);
      oe_cnt  += int'(DATA_OE);
      out_cnt += int'((|REG_ADDR) | (|BE));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic push(input ev_kind_t k, input logic [4:0] ra, input logic [3:0] be, input logic oe);
      ev_t e;
      e.kind = k; e.ra = ra; e.be = be; e.oe = oe;
      exp_q.push_back(e);
   endtask

   task automatic start_cycle(input logic [6:0] a, input logic [1:0] s, input logic rw,
                              input logic cs, input logic ds);
      ADDR = a; SIZ = s; RW = rw; CS = cs; AS = 1'b1; DS = ds;
      t0 = cyc;
   endtask

   task automatic release_bus();
      AS = 1'b0; DS = 1'b0; CS = 1'b0;
      tick(6);
   endtask

   task automatic wait_ack(input string nm);
      int i;
      i = 0;
      while (DSACK0 !== 1'b1 && i < 30) begin
         tick(1);
         i++;
      end
      n_cmp++;
      if (DSACK0 !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: DSACK0 not seen within 30 cycles, got %b, required 1", nm, DSACK0);
      end
   endtask

   logic [6:0] v_addr[4] = '{7'h0B, 7'h03, 7'h01, 7'h7E};
   logic [1:0] v_siz[4]  = '{2'b01, 2'b10, 2'b11, 2'b10};
   logic       v_rw[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [4:0] v_ra[4]   = '{5'd2, 5'd0, 5'd0, 5'd31};
   logic [3:0] v_be[4]   = '{4'b0001, 4'b0001, 4'b0111, 4'b0011};

   initial begin
      int s_stb, s_wr, s_ack, s_oe, s_out;
      RESET = 1'b1; AS = 1'b0; DS = 1'b0; RW = 1'b0; CS = 1'b0; ADDR = '0; SIZ = '0;
      tick(3);
      chk("rst_reg_addr", int'(REG_ADDR), 0);
      chk("rst_be", int'(BE), 0);
      chk("rst_rd_stb", int'(RD_STB), 0);
      chk("rst_wr_stb", int'(WR_STB), 0);
      chk("rst_data_oe", int'(DATA_OE), 0);
      chk("rst_dsack0", int'(DSACK0), 0);
      chk("rst_dsack1", int'(DSACK1), 0);
      RESET = 1'b0;
      tick(5);

      // Long read with AS and DS together: latency and hold behaviour.
      start_cycle(7'h14, 2'b00, 1'b1, 1'b1, 1'b1);
      push(EV_RD, 5'd5, 4'b1111, 1'b1);
      push(EV_ACK, 5'd5, 4'b1111, 1'b1);
      wait_ack("long_read_ack");
      tick(4);
      chk("long_read_rd_latency", rd_cyc - t0, 4);
      chk("long_read_ack_latency", ack_cyc - rd_cyc, 2);
      chk("long_read_dsack_held", int'(DSACK0), 1);
      chk("long_read_oe_held", int'(DATA_OE), 1);
      AS = 1'b0; DS = 1'b0;
      tick(4);
      chk("long_read_dsack_off", int'(DSACK0), 0);
      chk("long_read_oe_off", int'(DATA_OE), 0);
      release_bus();

      // Size/alignment table: byte write, misaligned word, 3-byte, top register.
      for (int i = 0; i < 4; i++) begin
         s_oe = oe_cnt;
         start_cycle(v_addr[i], v_siz[i], v_rw[i], 1'b1, 1'b1);
         if (v_rw[i]) push(EV_RD, v_ra[i], v_be[i], 1'b1);
         else         push(EV_WR, v_ra[i], v_be[i], 1'b0);
         push(EV_ACK, v_ra[i], v_be[i], v_rw[i]);
         wait_ack("table_ack");
         tick(2);
         release_bus();
         if (!v_rw[i]) chk("write_data_oe_cycles", oe_cnt - s_oe, 0);
      end

      // AS withdrawn while in WAIT, for a read and for a write.
      for (int r = 1; r >= 0; r--) begin
         s_wr = wr_cnt; s_ack = ack_cnt;
         start_cycle(7'h20, 2'b00, logic'(r), 1'b1, 1'b1);
         if (r == 1) push(EV_RD, 5'd8, 4'b1111, 1'b1);
         tick(2);
         AS = 1'b0; DS = 1'b0;
         tick(3);
         chk("abort_data_oe", int'(DATA_OE), 0);
         tick(5);
         chk("abort_dsack_cycles", ack_cnt - s_ack, 0);
         chk("abort_wr_cycles", wr_cnt - s_wr, 0);
         release_bus();
      end

      // DS never arrives: cycle abandoned; a late DS must not revive it.
      s_stb = stb_cnt; s_ack = ack_cnt; s_oe = oe_cnt;
      start_cycle(7'h10, 2'b00, 1'b1, 1'b1, 1'b0);
      tick(25);
      chk("timeout_strobes", stb_cnt - s_stb, 0);
      chk("timeout_dsack", ack_cnt - s_ack, 0);
      chk("timeout_data_oe", oe_cnt - s_oe, 0);
      DS = 1'b1;
      tick(8);
      chk("timeout_no_restart", stb_cnt - s_stb, 0);
      release_bus();

      // DS arriving late but inside the timeout window.
      start_cycle(7'h10, 2'b00, 1'b1, 1'b1, 1'b0);
      push(EV_RD, 5'd4, 4'b1111, 1'b1);
      push(EV_ACK, 5'd4, 4'b1111, 1'b1);
      tick(13);
      DS = 1'b1;
      wait_ack("late_ds_ack");
      tick(2);
      chk("late_ds_rd_latency", rd_cyc - t0, 16);
      release_bus();

      // Chip select miss: nothing may move.
      s_stb = stb_cnt; s_ack = ack_cnt; s_oe = oe_cnt; s_out = out_cnt;
      start_cycle(7'h14, 2'b00, 1'b1, 1'b0, 1'b1);
      tick(10);
      chk("cs_miss_strobes", stb_cnt - s_stb, 0);
      chk("cs_miss_dsack", ack_cnt - s_ack, 0);
      chk("cs_miss_data_oe", oe_cnt - s_oe, 0);
      chk("cs_miss_addr_be", out_cnt - s_out, 0);
      release_bus();

      // Reset while DSACK is held, then no restart until AS is re-asserted.
      start_cycle(7'h14, 2'b00, 1'b1, 1'b1, 1'b1);
      push(EV_RD, 5'd5, 4'b1111, 1'b1);
      push(EV_ACK, 5'd5, 4'b1111, 1'b1);
      wait_ack("reset_hold_ack");
      tick(2);
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      chk("reset_hold_dsack0", int'(DSACK0), 0);
      chk("reset_hold_dsack1", int'(DSACK1), 0);
      chk("reset_hold_data_oe", int'(DATA_OE), 0);
      s_stb = stb_cnt; s_ack = ack_cnt;
      tick(12);
      chk("reset_no_restart_strobes", stb_cnt - s_stb, 0);
      chk("reset_no_restart_dsack", ack_cnt - s_ack, 0);
      release_bus();
      start_cycle(7'h14, 2'b00, 1'b1, 1'b1, 1'b1);
      push(EV_RD, 5'd5, 4'b1111, 1'b1);
      push(EV_ACK, 5'd5, 4'b1111, 1'b1);
      wait_ack("after_reset_ack");
      tick(2);
      release_bus();

      tick(3);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
